sim_frame_gen: RTL

Parametrised stimulus source for bench and hardware-in-loop builds. It generates test frames on a periodic timer, a single-shot trigger or back-to-back, and streams them over a valid/ready interface into the BLVDS/uPP receive path. Frames carry a header, a channel/sequence tag, a selectable payload pattern and an XOR checksum. The channel tag rotates over a configurable channel count. It replaces the fixed-period counter plus fixed-format frame source used in simulation tops.

---
 rtl/sim_frame_gen.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/sim_frame_gen.sv
// Test frame source: periodic, single-shot or back-to-back frames on a valid/ready stream.
// Define SIM_FRAME_ERRINJ_EN to add the ierr_inj port (per-frame checksum inversion).
module sim_frame_gen #(
    parameter int unsigned       DATA_W    = 18,
    parameter int unsigned       CNT_W     = 26,
    parameter int unsigned       FRAME_LEN = 32,
    parameter int unsigned       CH_NUM    = 4,
    parameter logic [DATA_W-1:0] HEADER    = 18'h2F5F5,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ienable,
    input  logic [1:0]        imode,
    input  logic              istart,
    input  logic [CNT_W-1:0]  iperiod,
    input  logic [1:0]        ipattern,
    input  logic [DATA_W-1:0] ipat_word,
`ifdef SIM_FRAME_ERRINJ_EN
    input  logic              ierr_inj,
`endif
    input  logic              iready,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic              osof,
    output logic              oeof,
    output logic [3:0]        och,
    output logic [15:0]       oframe_cnt,
    output logic              oinit,
    output logic              ooverrun
);

    typedef enum logic [2:0] {StIdle, StHdr, StTag, StPay, StCsum} state_t;

    state_t            state;
    logic [CNT_W-1:0]  period_cnt;
    logic              start_prev;
    logic [1:0]        pat;
    logic [DATA_W-1:0] pat_word;
    logic [7:0]        idx;
    logic [15:0]       lfsr;
    logic [DATA_W-1:0] walk;
    logic [DATA_W-1:0] csum;
`ifdef SIM_FRAME_ERRINJ_EN
    logic              err_inj;
`endif

    logic              tick;
    logic              trigger;
    logic [7:0]        nxt_idx;
    logic [15:0]       nxt_lfsr;
    logic [DATA_W-1:0] nxt_walk;
    logic [DATA_W-1:0] pay_word;
    logic [DATA_W-1:0] tag_word;
    logic [DATA_W-1:0] csum_out;

    assign tick = (imode == 2'd0) && ienable && (iperiod != '0) &&
                  (period_cnt >= iperiod - CNT_W'(1));

    always_comb begin
        case (imode)
            2'd0:    trigger = tick;
            2'd1:    trigger = ienable && istart && !start_prev;
            2'd2:    trigger = ienable && (state == StIdle);
            default: trigger = 1'b0;
        endcase
    end

    // Next payload word: the TAG transfer loads word 0, each PAY transfer loads word i+1.
    always_comb begin
        nxt_idx  = (state == StTag) ? 8'd0 : idx + 8'd1;
        nxt_lfsr = (state == StTag) ? lfsr : {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        nxt_walk = (state == StTag) ? walk : {walk[DATA_W-2:0], walk[DATA_W-1]};
        pay_word = '0;
        case (pat)
            2'd0:    pay_word[7:0]  = nxt_idx;
            2'd1:    pay_word       = pat_word;
            2'd2:    pay_word[15:0] = nxt_lfsr;
            default: pay_word       = nxt_walk;
        endcase
        tag_word        = '0;
        tag_word[11:0]  = {och, oframe_cnt[7:0]};
        csum_out        = csum;
`ifdef SIM_FRAME_ERRINJ_EN
        if (err_inj) csum_out = ~csum;
`endif
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state      <= StIdle;
            period_cnt <= '0;
            start_prev <= 1'b0;
            pat        <= 2'd0;
            pat_word   <= '0;
            idx        <= 8'd0;
            lfsr       <= LFSR_SEED;
            walk       <= DATA_W'(1);
            csum       <= '0;
`ifdef SIM_FRAME_ERRINJ_EN
            err_inj    <= 1'b0;
`endif
            odata      <= '0;
            ovalid     <= 1'b0;
            osof       <= 1'b0;
            oeof       <= 1'b0;
            och        <= 4'd0;
            oframe_cnt <= 16'd0;
            oinit      <= 1'b0;
            ooverrun   <= 1'b0;
        end else begin
            oinit      <= 1'b0;
            start_prev <= istart;
            if ((imode == 2'd0) && ienable && (iperiod != '0)) begin
                period_cnt <= tick ? '0 : period_cnt + CNT_W'(1);
            end else begin
                period_cnt <= '0;
            end
            if (trigger && (state != StIdle)) ooverrun <= 1'b1;

            case (state)
                StIdle: begin
                    if (trigger) begin
                        state    <= StHdr;
                        oinit    <= 1'b1;
                        pat      <= ipattern;
                        pat_word <= ipat_word;
                        lfsr     <= LFSR_SEED;
                        walk     <= DATA_W'(1);
`ifdef SIM_FRAME_ERRINJ_EN
                        err_inj  <= ierr_inj;
`endif
                    end
                end
                StHdr: begin
                    // First HDR cycle is the oinit cycle; the header is presented one clock later.
                    if (!ovalid) begin
                        ovalid <= 1'b1;
                        osof   <= 1'b1;
                        odata  <= HEADER;
                        csum   <= HEADER;
                    end else if (iready) begin
                        state  <= StTag;
                        osof   <= 1'b0;
                        odata  <= tag_word;
                        csum   <= csum ^ tag_word;
                    end
                end
                StTag: begin
                    if (iready) begin
                        state <= StPay;
                        idx   <= nxt_idx;
                        lfsr  <= nxt_lfsr;
                        walk  <= nxt_walk;
                        odata <= pay_word;
                        csum  <= csum ^ pay_word;
                    end
                end
                StPay: begin
                    if (iready) begin
                        if (idx == 8'(FRAME_LEN - 1)) begin
                            state <= StCsum;
                            odata <= csum_out;
                            oeof  <= 1'b1;
                        end else begin
                            idx   <= nxt_idx;
                            lfsr  <= nxt_lfsr;
                            walk  <= nxt_walk;
                            odata <= pay_word;
                            csum  <= csum ^ pay_word;
                        end
                    end
                end
                StCsum: begin
                    if (iready) begin
                        state      <= StIdle;
                        ovalid     <= 1'b0;
                        oeof       <= 1'b0;
                        oframe_cnt <= oframe_cnt + 16'd1;
                        och        <= (och == 4'(CH_NUM - 1)) ? 4'd0 : och + 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
